voice_allocator: RTL and testbench

Polyphonic voice scheduler for the audio synth. It accepts note-on/note-off events and assigns each note to one of VOICES oscillator+AR envelope pairs. For each voice it drives the `gate` and phase `increment`, stealing the oldest voice when all voices are busy. It sits between the CPU-side note register interface and the bank of oscillator/ar instances that run off `sample_clock`.

---
 rtl/voice_allocator.sv | 219 +++++++++++++++++++++
 tb/tb_voice_allocator.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/voice_allocator.sv
// voice_allocator: polyphonic voice scheduler.
// Note-on/note-off events are assigned to VOICES oscillator+AR voice pairs;
// each voice drives a gate, a phase increment and the key it holds.
// Optional feature macro: VOICE_STEAL_EN (oldest-busy-voice stealing with a
// wait for a sample_clock edge so the envelope sees the gate drop).
module voice_allocator #(
    parameter int VOICES   = 4,
    parameter int INCWIDTH = 16
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       sample_clock,
    input  logic                       ev_valid,
    output logic                       ev_ready,
    input  logic                       ev_note_on,
    input  logic [6:0]                 ev_key,
    input  logic [INCWIDTH-1:0]        ev_increment,
    output logic [VOICES-1:0]          gate,
    output logic [VOICES*INCWIDTH-1:0] increment,
    output logic [VOICES*7-1:0]        voice_key
);

    localparam int            IW   = (VOICES > 1) ? $clog2(VOICES) : 1;
    localparam logic [IW-1:0] LAST = IW'(VOICES - 1);

`ifdef VOICE_STEAL_EN
    typedef enum logic [1:0] {IDLE, SCAN, WAIT_EDGE, COMMIT} state_t;
`else
    typedef enum logic [1:0] {IDLE, SCAN, COMMIT} state_t;
`endif

    state_t                state;
    logic [IW-1:0]         scan_idx;

    logic                  lat_on;
    logic [6:0]            lat_key;
    logic [INCWIDTH-1:0]   lat_inc;

    logic [6:0]            key_r [VOICES];
    logic [INCWIDTH-1:0]   inc_r [VOICES];
    logic [7:0]            age   [VOICES];

    logic                  sc_d;
    logic                  sc_edge;

    logic                  hit_found, hit_n;
    logic [IW-1:0]         hit_idx, hit_idx_n;
    logic                  free_found, free_n;
    logic [IW-1:0]         free_idx, free_idx_n;

    logic                  do_write;
    logic [IW-1:0]         target;

`ifdef VOICE_STEAL_EN
    logic                  old_found, old_n;
    logic [IW-1:0]         old_idx, old_idx_n;
    logic [7:0]            old_age, old_age_n;
`endif

    assign sc_edge = sample_clock & ~sc_d;

    // Fold the voice under inspection into the running match/free/oldest candidates
    always_comb begin
        hit_n      = hit_found;
        hit_idx_n  = hit_idx;
        free_n     = free_found;
        free_idx_n = free_idx;
`ifdef VOICE_STEAL_EN
        old_n      = old_found;
        old_idx_n  = old_idx;
        old_age_n  = old_age;
`endif
        if (state == SCAN) begin
            if (gate[scan_idx] && (key_r[scan_idx] == lat_key) && !hit_found) begin
                hit_n     = 1'b1;
                hit_idx_n = scan_idx;
            end
            if (!gate[scan_idx] && !free_found) begin
                free_n     = 1'b1;
                free_idx_n = scan_idx;
            end
`ifdef VOICE_STEAL_EN
            // strict '>' keeps the lowest index on equal ages
            if (gate[scan_idx] && (!old_found || (age[scan_idx] > old_age))) begin
                old_n     = 1'b1;
                old_idx_n = scan_idx;
                old_age_n = age[scan_idx];
            end
`endif
        end
    end

    // Event FSM, per-voice state and age counters
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= IDLE;
            ev_ready   <= 1'b0;
            scan_idx   <= '0;
            lat_on     <= 1'b0;
            lat_key    <= '0;
            lat_inc    <= '0;
            gate       <= '0;
            sc_d       <= sample_clock;
            hit_found  <= 1'b0;
            hit_idx    <= '0;
            free_found <= 1'b0;
            free_idx   <= '0;
            do_write   <= 1'b0;
            target     <= '0;
`ifdef VOICE_STEAL_EN
            old_found  <= 1'b0;
            old_idx    <= '0;
            old_age    <= '0;
`endif
            for (int unsigned v = 0; v < VOICES; v++) begin
                key_r[v] <= '0;
                inc_r[v] <= '0;
                age[v]   <= '0;
            end
        end else begin
            sc_d <= sample_clock;
            for (int unsigned v = 0; v < VOICES; v++) begin
                if (sc_edge && (age[v] != 8'hFF))
                    age[v] <= age[v] + 8'd1;
            end

            hit_found  <= hit_n;
            hit_idx    <= hit_idx_n;
            free_found <= free_n;
            free_idx   <= free_idx_n;
`ifdef VOICE_STEAL_EN
            old_found  <= old_n;
            old_idx    <= old_idx_n;
            old_age    <= old_age_n;
`endif

            case (state)
                IDLE: begin
                    ev_ready <= 1'b1;
                    if (ev_valid && ev_ready) begin
                        lat_on     <= ev_note_on;
                        lat_key    <= ev_key;
                        lat_inc    <= ev_increment;
                        scan_idx   <= '0;
                        hit_found  <= 1'b0;
                        free_found <= 1'b0;
`ifdef VOICE_STEAL_EN
                        old_found  <= 1'b0;
`endif
                        ev_ready   <= 1'b0;
                        state      <= SCAN;
                    end
                end

                SCAN: begin
                    scan_idx <= scan_idx + IW'(1);
                    if (scan_idx == LAST) begin
                        state    <= COMMIT;
                        do_write <= 1'b0;
                        target   <= hit_idx_n;
                        if (lat_on) begin
                            if (hit_n) begin
                                do_write <= 1'b1;
                            end else if (free_n) begin
                                do_write <= 1'b1;
                                target   <= free_idx_n;
                            end else begin
`ifdef VOICE_STEAL_EN
                                do_write          <= 1'b1;
                                target            <= old_idx_n;
                                gate[old_idx_n]   <= 1'b0;
                                state             <= WAIT_EDGE;
`endif
                            end
                        end else begin
                            do_write <= hit_n;
                        end
                    end
                end

`ifdef VOICE_STEAL_EN
                WAIT_EDGE: begin
                    if (sc_edge)
                        state <= COMMIT;
                end
`endif

                COMMIT: begin
                    if (do_write) begin
                        if (lat_on) begin
                            gate[target]  <= 1'b1;
                            key_r[target] <= lat_key;
                            inc_r[target] <= lat_inc;
                            // overrides the sample-edge increment issued above
                            age[target]   <= '0;
                        end else begin
                            gate[target]  <= 1'b0;
                        end
                    end
                    ev_ready <= 1'b1;
                    state    <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

    // Pack per-voice registers onto the flat output buses
    always_comb begin
        increment = '0;
        voice_key = '0;
        for (int unsigned v = 0; v < VOICES; v++) begin
            increment[v*INCWIDTH +: INCWIDTH] = inc_r[v];
            voice_key[v*7 +: 7]               = key_r[v];
        end
    end

endmodule

// File: tb/tb_voice_allocator.sv
// Self-checking bench for voice_allocator (VOICES=4, INCWIDTH=16).
// Follows VOICE_STEAL_EN the same way as the design build.
module tb_voice_allocator;

    localparam int V = 4;
    localparam int W = 16;

`ifdef VOICE_STEAL_EN
    localparam bit STEAL = 1'b1;
`else
    localparam bit STEAL = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           resetn = 1'b0;
    logic           sample_clock = 1'b0;
    logic           ev_valid = 1'b0;
    logic           ev_ready;
    logic           ev_note_on = 1'b0;
    logic [6:0]     ev_key = '0;
    logic [W-1:0]   ev_increment = '0;
    logic [V-1:0]   gate;
    logic [V*W-1:0] increment;
    logic [V*7-1:0] voice_key;

    voice_allocator #(.VOICES(V), .INCWIDTH(W)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .sample_clock (sample_clock),
        .ev_valid     (ev_valid),
        .ev_ready     (ev_ready),
        .ev_note_on   (ev_note_on),
        .ev_key       (ev_key),
        .ev_increment (ev_increment),
        .gate         (gate),
        .increment    (increment),
        .voice_key    (voice_key)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // reference model: what each voice holds
    int m_gate [V];
    int m_key  [V];
    int m_inc  [V];
    int m_age  [V];

    typedef struct {
        bit on;
        int key;
        int inc;
        int exp_gate;
        int exp_voice;
    } vec_t;

    function automatic int key_of(int v);
        logic [6:0] k;
        k = voice_key[v*7 +: 7];
        return int'(k);
    endfunction

    function automatic int inc_of(int v);
        logic [W-1:0] i;
        i = increment[v*W +: W];
        return int'(i);
    endfunction

    task automatic cmp(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_state(input string tag, input int victim);
        int eg;
        eg = 0;
        for (int i = 0; i < V; i++)
            if (m_gate[i] != 0 && i != victim) eg |= (1 << i);
        cmp({tag, " gate"}, int'(gate), eg);
        for (int i = 0; i < V; i++) begin
            cmp($sformatf("%s v%0d key", tag, i), key_of(i), m_key[i]);
            cmp($sformatf("%s v%0d inc", tag, i), inc_of(i), m_inc[i]);
        end
    endtask

    task automatic age_all();
        for (int i = 0; i < V; i++)
            if (m_age[i] < 255) m_age[i]++;
    endtask

    task automatic model_reset();
        for (int i = 0; i < V; i++) begin
            m_gate[i] = 0; m_key[i] = 0; m_inc[i] = 0; m_age[i] = 0;
        end
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        resetn = 1'b0;
        ev_valid = 1'b0;
        @(posedge clk); #1;
        model_reset();
        check_state({tag, " in reset"}, -1);
        cmp({tag, " ready in reset"}, int'(ev_ready), 0);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk); #1;
        cmp({tag, " ready after release"}, int'(ev_ready), 1);
    endtask

    // idle sample_clock pulses, FSM known to be in IDLE
    task automatic pulse_idle(input int n);
        for (int p = 0; p < n; p++) begin
            @(negedge clk); sample_clock = 1'b1;
            @(negedge clk); sample_clock = 1'b0;
            age_all();
        end
    endtask

    // One event; c = clk edge (after acceptance) at which a sample_clock
    // rising edge is seen, 0 = none.
    task automatic run_event(input bit on, input int key, input int inc,
                             input int c_in, input string tag);
        int  tgt, best, L, c, kmax;
        bit  steal, wr;
        c     = c_in;
        tgt   = -1;
        steal = 1'b0;
        for (int i = 0; i < V; i++)
            if (tgt < 0 && m_gate[i] != 0 && m_key[i] == key) tgt = i;
        if (on && tgt < 0)
            for (int i = 0; i < V; i++)
                if (tgt < 0 && m_gate[i] == 0) tgt = i;
        if (on && tgt < 0 && STEAL) begin
            steal = 1'b1;
            best  = 0;
            for (int i = 1; i < V; i++)
                if (m_age[i] > m_age[best]) best = i;
            tgt = best;
        end
        if (steal && c < V + 1) c = V + 1 + (c % 4);
        L    = steal ? c + 1 : V + 1;
        wr   = on && (tgt >= 0);
        kmax = (c > L) ? c : L;

        @(negedge clk);
        cmp({tag, " ready before"}, int'(ev_ready), 1);
        ev_valid     = 1'b1;
        ev_note_on   = on;
        ev_key       = 7'(key);
        ev_increment = W'(inc);
        @(posedge clk); #1;
        ev_valid = 1'b0;
        cmp({tag, " ready after accept"}, int'(ev_ready), 0);

        for (int k = 1; k <= kmax; k++) begin
            @(negedge clk);
            sample_clock = (k == c);
            @(posedge clk); #1;
            if (k < L) begin
                check_state($sformatf("%s k%0d", tag, k), (steal && k >= V) ? tgt : -1);
                cmp($sformatf("%s k%0d ready", tag, k), int'(ev_ready), 0);
            end else if (k == L) begin
                if (tgt >= 0) begin
                    if (on) begin
                        m_gate[tgt] = 1; m_key[tgt] = key; m_inc[tgt] = inc;
                    end else begin
                        m_gate[tgt] = 0;
                    end
                end
                check_state($sformatf("%s done", tag), -1);
                cmp({tag, " ready done"}, int'(ev_ready), 1);
            end
        end
        @(negedge clk);
        sample_clock = 1'b0;

        if (c > 0 && c <= L) begin
            age_all();
            if (wr) m_age[tgt] = 0;
        end else begin
            if (wr) m_age[tgt] = 0;
            if (c > 0) age_all();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t tbl [7];
        tbl[0] = '{1'b1, 60, 'h0893, 'b0001,  0};
        tbl[1] = '{1'b1, 64, 'h0ACD, 'b0011,  1};
        tbl[2] = '{1'b1, 67, 'h0CDE, 'b0111,  2};
        tbl[3] = '{1'b1, 72, 'h1126, 'b1111,  3};
        tbl[4] = '{1'b0, 64, 'h0000, 'b1101, -1};
        tbl[5] = '{1'b0, 99, 'h0000, 'b1101, -1};
        tbl[6] = '{1'b1, 67, 'h0CE0, 'b1101,  2};

        model_reset();
        do_reset("init");

        // table-driven: allocation, fill, note-off, unmatched note-off, retrigger
        for (int t = 0; t < 7; t++) begin
            run_event(tbl[t].on, tbl[t].key, tbl[t].inc, 0, $sformatf("tbl%0d", t));
            cmp($sformatf("tbl%0d gate", t), int'(gate), tbl[t].exp_gate);
            if (tbl[t].exp_voice >= 0) begin
                cmp($sformatf("tbl%0d key", t), key_of(tbl[t].exp_voice), tbl[t].key);
                cmp($sformatf("tbl%0d inc", t), inc_of(tbl[t].exp_voice), tbl[t].inc);
            end
        end
        cmp("released v1 key", key_of(1), 64);
        cmp("released v1 inc", inc_of(1), 'h0ACD);

        // steal with ages 40,30,20,10
        do_reset("steal");
        run_event(1'b1, 60, 'h0100, 0, "st60"); pulse_idle(10);
        run_event(1'b1, 64, 'h0200, 0, "st64"); pulse_idle(10);
        run_event(1'b1, 67, 'h0300, 0, "st67"); pulse_idle(10);
        run_event(1'b1, 72, 'h0400, 0, "st72"); pulse_idle(10);
        run_event(1'b1, 76, 'h0500, 7, "st76");
        cmp("steal gate", int'(gate), 'b1111);
        cmp("steal v0 key", key_of(0), STEAL ? 76 : 60);
        cmp("steal v1 key", key_of(1), 64);

        // sample edge coinciding with COMMIT: committed voice 0, others +1
        do_reset("coin");
        run_event(1'b1, 60, 'h0111, 0, "co60");
        run_event(1'b1, 64, 'h0222, 0, "co64");
        run_event(1'b0, 60, 'h0000, 0, "co_off60");
        run_event(1'b1, 67, 'h0333, V + 1, "co67");
        run_event(1'b1, 72, 'h0444, 0, "co72");
        run_event(1'b1, 76, 'h0555, 0, "co76");
        run_event(1'b1, 79, 'h0666, V + 2, "co79");
        cmp("coin v1 key", key_of(1), STEAL ? 79 : 64);
        cmp("coin v0 key", key_of(0), 67);

        // age saturation: all saturate to 255, tie goes to voice 0
        do_reset("sat");
        run_event(1'b1, 60, 'h1000, 0, "sa60");
        run_event(1'b1, 64, 'h2000, 0, "sa64");
        run_event(1'b1, 67, 'h3000, 0, "sa67");
        run_event(1'b1, 72, 'h4000, 0, "sa72");
        run_event(1'b0, 60, 'h0000, 0, "sa_off60");
        run_event(1'b1, 61, 'h5000, 0, "sa61");
        pulse_idle(300);
        run_event(1'b1, 80, 'h6000, V + 1, "sa80");
        cmp("sat v0 key", key_of(0), STEAL ? 80 : 61);

        // reset during SCAN aborts the event
        do_reset("mid");
        run_event(1'b1, 50, 'h0777, 0, "mid50");
        @(negedge clk);
        ev_valid = 1'b1; ev_note_on = 1'b1; ev_key = 7'd51; ev_increment = 16'h0888;
        @(posedge clk); #1;
        ev_valid = 1'b0;
        @(posedge clk); #1;
        do_reset("midrst");
        run_event(1'b1, 52, 'h0999, 0, "after_mid");
        cmp("after mid gate", int'(gate), 'b0001);

        // randomized events against the model
        do_reset("rand");
        for (int n = 0; n < 300; n++) begin
            bit on;
            on = ($urandom_range(0, 99) < 65);
            run_event(on, 60 + $urandom_range(0, 7), $urandom_range(0, 65535),
                      $urandom_range(0, 7), $sformatf("r%0d", n));
            pulse_idle($urandom_range(0, 3));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
